// File: rtl/gf24_scalarsquare_pipe.sv
// Share-wise GF(2^4) scalar-square unit (lambda*x^2, composite-field basis) with a
// per-beat mode select, carried through an elastic, globally stalled register pipeline.
module gf24_scalarsquare_pipe #(
  parameter int LANES  = 4,
  parameter int SHARES = 2,
  parameter int STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                in_mode,
  input  logic [LANES*SHARES*4-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*SHARES*4-1:0] out_data,
  output logic                      busy
);

  localparam int NIBS = LANES * SHARES;
  localparam int W    = NIBS * 4;
  // The mode is consumed before the final register, so that slot never stores it.
  localparam int MODE_SLOTS = (STAGES == 1) ? 1 : STAGES - 1;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_SQ   = 2'd1,
    MODE_SQSQ = 2'd2,
    MODE_XSQ  = 2'd3
  } mode_e;

  function automatic logic [3:0] sq_scale(input logic [3:0] x);
    return {x[2] ^ x[1] ^ x[0], x[3] ^ x[0], x[3], x[3] ^ x[2]};
  endfunction

  // Each nibble (one share of one lane) is transformed in isolation; shares never mix.
  function automatic logic [W-1:0] apply_mode(input logic [1:0] mode, input logic [W-1:0] d);
    logic [W-1:0] r;
    logic [3:0]   x;
    r = '0;
    for (int k = 0; k < NIBS; k++) begin
      x = d[4*k +: 4];
      case (mode_e'(mode))
        MODE_PASS: r[4*k +: 4] = x;
        MODE_SQ:   r[4*k +: 4] = sq_scale(x);
        MODE_SQSQ: r[4*k +: 4] = sq_scale(sq_scale(x));
        MODE_XSQ:  r[4*k +: 4] = x ^ sq_scale(x);
      endcase
    end
    return r;
  endfunction

  logic [STAGES-1:0]               vld_q, vld_d;
  logic [MODE_SLOTS-1:0][1:0]      mode_q, mode_d;
  logic [STAGES-1:0][W-1:0]        data_q, data_d;
  logic [W-1:0]                    fn_data;
  logic                            advance;

  assign advance   = out_ready | ~out_valid;
  assign in_ready  = advance;
  assign out_valid = vld_q[STAGES-1];
  assign busy      = |vld_q;
  assign fn_data   = apply_mode(mode_q[MODE_SLOTS-1], data_q[MODE_SLOTS-1]);
  assign out_data  = (STAGES == 1) ? fn_data : data_q[STAGES-1];

  always_comb begin
    // NOTE: every next-state signal gets a hold default first so no path infers a latch.
    vld_d  = vld_q;
    mode_d = mode_q;
    data_d = data_q;
    if (advance) begin
      vld_d[0] = in_valid;
      if (in_valid) begin
        mode_d[0] = in_mode;
        data_d[0] = in_data;
      end
      for (int i = 1; i < MODE_SLOTS; i++) mode_d[i] = mode_q[i-1];
      for (int i = 1; i < STAGES; i++) begin
        vld_d[i]  = vld_q[i-1];
        data_d[i] = (i == STAGES - 1) ? fn_data : data_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: payload registers are cleared too, so out_data reads 0 straight after reset.
    if (rst) begin
      vld_q  <= '0;
      mode_q <= '0;
      data_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every slot sampling pre-edge values.
      vld_q  <= vld_d;
      mode_q <= mode_d;
      data_q <= data_d;
    end
  end

endmodule

// File: tb/tb_gf24_scalarsquare_pipe.sv
// Self-checking bench: three pipeline depths (1, 2, 4) share one stimulus stream,
// each scored against a linear-map reference model of the nibble function.
module tb_gf24_scalarsquare_pipe;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] din;
    logic [1:0]   mode;
    int           cyc;
  } beat_t;

  logic             clk;
  logic             rst;
  logic [2:0]       in_valid, in_ready, out_valid, out_ready, busy;
  logic [1:0]       in_mode  [3];
  logic [W-1:0]     in_data  [3];
  logic [W-1:0]     out_data [3];
  int               cyc;
  int               total;
  int               bad;
  logic             lat_chk;
  logic             chk_empty;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // S is GF(2)-linear: images of the basis nibbles 1,2,4,8 are C,8,9,7.
  function automatic logic [3:0] s_ref(input logic [3:0] x);
    logic [15:0] cols;
    logic [3:0]  r;
    cols = 16'h798C;
    r    = '0;
    for (int i = 0; i < 4; i++) if (x[i]) r ^= cols[4*i +: 4];
    return r;
  endfunction

  function automatic logic [3:0] mode_ref(input logic [1:0] m, input logic [3:0] x);
    case (m)
      2'd0:    return x;
      2'd1:    return s_ref(x);
      2'd2:    return s_ref(s_ref(x));
      default: return x ^ s_ref(x);
    endcase
  endfunction

  function automatic logic [W-1:0] ref_word(input logic [1:0] m, input logic [W-1:0] d);
    logic [W-1:0] r;
    for (int k = 0; k < 8; k++) r[4*k +: 4] = mode_ref(m, d[4*k +: 4]);
    return r;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int DEPTH = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    beat_t        sb[$];
    beat_t        b;
    logic [15:0]  xo, xi, xe;

    gf24_scalarsquare_pipe #(.LANES(4), .SHARES(2), .STAGES(DEPTH)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_mode   (in_mode[g]),
      .in_data   (in_data[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
      .busy      (busy[g])
    );

    always @(negedge clk) begin
      if (rst) begin
        sb.delete();
      end else begin
        if (out_valid[g] && out_ready[g]) begin
          if (sb.size() == 0) begin
            check($sformatf("s%0d_unexpected_beat", DEPTH), out_data[g], '0);
            check($sformatf("s%0d_unexpected_valid", DEPTH), 32'd1, 32'd0);
          end else begin
            b = sb.pop_front();
            check($sformatf("s%0d_data", DEPTH), out_data[g], ref_word(b.mode, b.din));
            for (int l = 0; l < 4; l++) begin
              xo[4*l +: 4] = out_data[g][8*l +: 4] ^ out_data[g][8*l+4 +: 4];
              xi[4*l +: 4] = b.din[8*l +: 4] ^ b.din[8*l+4 +: 4];
              xe[4*l +: 4] = mode_ref(b.mode, xi[4*l +: 4]);
            end
            check($sformatf("s%0d_share_xor", DEPTH), {16'd0, xo}, {16'd0, xe});
            if (lat_chk) check($sformatf("s%0d_latency", DEPTH), cyc - b.cyc, DEPTH);
          end
        end
        if (in_valid[g] && in_ready[g]) sb.push_back('{din: in_data[g], mode: in_mode[g], cyc: cyc});
        if (chk_empty) check($sformatf("s%0d_drained", DEPTH), sb.size(), 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic [W-1:0] d);
    in_valid = {3{v}};
    for (int g = 0; g < 3; g++) begin
      in_mode[g] = m;
      in_data[g] = d;
    end
  endtask

  // Four back-to-back beats into an empty pipe; checks the depth-2 instance each cycle.
  task automatic burst(input string tag, input logic [15:0] xs, input logic [7:0] ms,
                       input logic [15:0] ex);
    out_ready = '1;
    for (int j = 0; j < 5; j++) begin
      if (j < 4) drive(1'b1, ms[2*j +: 2], {8{xs[4*j +: 4]}});
      else       drive(1'b0, 2'd0, '0);
      step();
      if (j >= 1) begin
        check({tag, "_valid"}, out_valid[1], 1);
        check(tag, out_data[1], {8{ex[4*(j-1) +: 4]}});
      end
    end
    repeat (5) step();
  endtask

  logic [W-1:0] bd[8];
  logic [1:0]   bm[8];
  int           idx;

  initial begin
    total = 0; bad = 0; lat_chk = 1'b0; chk_empty = 1'b0;
    rst = 1'b1; out_ready = '0;
    drive(1'b0, 2'd0, '0);
    repeat (3) step();
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 3'b111);
    for (int g = 0; g < 3; g++) check($sformatf("rst_out_data%0d", g), out_data[g], 0);
    rst = 1'b0;
    step();
    check("post_rst_in_ready", in_ready, 3'b111);

    burst("s_sequence", 16'h6F81, 8'b01010101, 16'h1A7C);
    burst("mode_sweep", 16'h1111, 8'b11100100, 16'hDEC1);

    drive(1'b1, 2'd1, 32'h61616161);
    step();
    drive(1'b0, 2'd0, '0);
    step();
    check("shares_out", out_data[1], 32'h1C1C1C1C);
    repeat (5) step();

    // Backpressure: out_ready low for three cycles while beat 3 sits at the output.
    for (int i = 0; i < 8; i++) begin
      bd[i] = $urandom;
      bm[i] = 2'($urandom_range(0, 3));
    end
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      out_ready = (c >= 5 && c <= 7) ? 3'b000 : 3'b111;
      #1;
      if (c >= 5 && c <= 7) begin
        check("stall_out_valid", out_valid[1], 1);
        check("stall_in_ready", in_ready[1], 0);
        check("stall_out_data", out_data[1], ref_word(bm[3], bd[3]));
      end
      if (idx < 8) drive(1'b1, bm[idx], bd[idx]);
      else         drive(1'b0, 2'd0, '0);
      if (idx < 8 && in_ready[1]) idx++;
      step();
    end
    check("stall_all_sent", idx, 8);
    drive(1'b0, 2'd0, '0);
    repeat (5) step();

    // Reset with two beats in flight; a beat offered during reset is ignored.
    out_ready = '0;
    drive(1'b1, 2'd1, 32'hA5A5A5A5);
    step();
    drive(1'b1, 2'd2, 32'h3C3C3C3C);
    step();
    rst = 1'b1;
    drive(1'b1, 2'd3, 32'h77777777);
    step();
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    rst = 1'b0;
    drive(1'b0, 2'd0, '0);
    out_ready = '1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("after_rst_quiet", out_valid, 0);
    end
    drive(1'b1, 2'd2, 32'h11111111);
    step();
    drive(1'b0, 2'd0, '0);
    check("after_rst_not_early", out_valid[1], 0);
    step();
    check("after_rst_valid", out_valid[1], 1);
    check("after_rst_data", out_data[1], 32'hEEEEEEEE);
    repeat (6) step();

    // Full-throughput random stream: latency must be exactly the stage count.
    lat_chk = 1'b1;
    out_ready = '1;
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom);
      step();
    end
    drive(1'b0, 2'd0, '0);
    repeat (6) step();
    lat_chk = 1'b0;

    // Random stream with independent random backpressure per instance.
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom);
      for (int g = 0; g < 3; g++) out_ready[g] = ($urandom_range(0, 3) != 0);
      step();
    end
    drive(1'b0, 2'd0, '0);
    out_ready = '1;
    repeat (8) step();
    chk_empty = 1'b1;
    step();
    chk_empty = 1'b0;
    check("final_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
